// File: rtl/vram_pkg.sv
// rtl/vram_pkg.sv - shared framebuffer constants, grant/FSM types and display address helper
package vram_pkg;
  localparam int FB_W    = 160;
  localparam int FB_H    = 120;
  localparam int FB_SIZE = FB_W * FB_H;
  localparam int VRAM_AW = 15;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} cpu_st_t;
  typedef enum logic [1:0] {GNT_NONE, GNT_DISP, GNT_CPU, GNT_CLR} gnt_t;

  function automatic logic [VRAM_AW-1:0] disp_addr(input logic [6:0] row, input logic [7:0] col);
    return VRAM_AW'(row) * VRAM_AW'(FB_W) + VRAM_AW'(col);
  endfunction
endpackage

// File: rtl/vram_clear.sv
// rtl/vram_clear.sv - framebuffer fill engine: ascending address counter with req/gnt handshake
module vram_clear
  import vram_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [7:0]         color,
  input  logic               gnt,
  output logic               req,
  output logic               busy,
  output logic [VRAM_AW-1:0] addr,
  output logic [7:0]         data
);
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [VRAM_AW-1:0] addr_q, addr_d;
  logic [7:0]         color_q, color_d;

  always_comb begin
    busy_d  = busy_q;
    done_d  = done_q;
    addr_d  = addr_q;
    color_d = color_q;
    if (!busy_q) begin
      if (start) begin
        busy_d  = 1'b1;
        addr_d  = '0;
        color_d = color;
      end
    end else if (done_q) begin
      // last write occupies the VRAM bus now; busy drops right after it
      busy_d = 1'b0;
      done_d = 1'b0;
    end else if (gnt) begin
      if (addr_q == VRAM_AW'(FB_SIZE - 1)) done_d = 1'b1;
      else addr_d = addr_q + VRAM_AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      color_q <= '0;
    end else begin
      busy_q  <= busy_d;
      done_q  <= done_d;
      addr_q  <= addr_d;
      color_q <= color_d;
    end
  end

  assign req  = busy_q && !done_q;
  assign busy = busy_q;
  assign addr = addr_q;
  assign data = color_q;
endmodule

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - VRAM scheduler: display slots first, CPU and fill engine round-robin
// The fill engine and round-robin are built only when VRAM_ARB_CLEAR_EN is defined.
module vram_arbiter
  import vram_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clk_pix,
  input  logic               vis,
  input  logic [9:0]         x,
  input  logic [8:0]         y,
  output logic [7:0]         pix_data,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [VRAM_AW-1:0] cpu_addr,
  input  logic [7:0]         cpu_wdata,
  output logic               cpu_ack,
  output logic [7:0]         cpu_rdata,
  input  logic               clear_start,
  input  logic [7:0]         clear_color,
  output logic               clear_busy,
  output logic               vram_en,
  output logic               vram_we,
  output logic [VRAM_AW-1:0] vram_addr,
  output logic [7:0]         vram_wdata,
  input  logic [7:0]         vram_rdata
);
  logic               disp_slot, pix_tick, cpu_pend;
  logic               clr_req, clr_gnt, clr_busy;
  logic [VRAM_AW-1:0] clr_addr;
  logic [7:0]         clr_data;
  gnt_t               gnt;

  cpu_st_t            cpu_st_q, cpu_st_d;
  logic               cpu_we_q, cpu_we_d;
  logic               cpu_ack_q, cpu_ack_d;
  logic [7:0]         cpu_rdata_q, cpu_rdata_d;
  logic               last_cpu_q, last_cpu_d;
  logic               vram_en_q, vram_en_d;
  logic               vram_we_q, vram_we_d;
  logic [VRAM_AW-1:0] vram_addr_q, vram_addr_d;
  logic [7:0]         vram_wdata_q, vram_wdata_d;
  logic [2:0]         tick_q, tick_d;
  logic [1:0]         dvld_q, dvld_d;
  logic [7:0]         pix_hold_q, pix_hold_d;
  logic [7:0]         pix_data_q, pix_data_d;

  logic unused_bits;
  assign unused_bits = ^y[1:0];

`ifdef VRAM_ARB_CLEAR_EN
  vram_clear u_clear (
    .clk   (clk),
    .rst   (rst),
    .start (clear_start),
    .color (clear_color),
    .gnt   (clr_gnt),
    .req   (clr_req),
    .busy  (clr_busy),
    .addr  (clr_addr),
    .data  (clr_data)
  );
`else
  assign clr_req  = 1'b0;
  assign clr_busy = 1'b0;
  assign clr_addr = '0;
  assign clr_data = '0;
  logic unused_clear;
  assign unused_clear = ^{clear_start, clear_color, clr_gnt};
`endif

  assign clr_gnt = (gnt == GNT_CLR);

  always_comb begin
    pix_tick  = !clk_pix && (x[1:0] == 2'b00);
    disp_slot = pix_tick && vis;
    cpu_pend  = (cpu_st_q == IDLE) && cpu_req;

    gnt = GNT_NONE;
    if (disp_slot)              gnt = GNT_DISP;
    else if (cpu_pend && clr_req) gnt = last_cpu_q ? GNT_CLR : GNT_CPU;
    else if (cpu_pend)          gnt = GNT_CPU;
    else if (clr_req)           gnt = GNT_CLR;

    cpu_st_d    = cpu_st_q;
    cpu_we_d    = cpu_we_q;
    cpu_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    case (cpu_st_q)
      IDLE: if (gnt == GNT_CPU) begin
        cpu_st_d = ISSUE;
        cpu_we_d = cpu_we;
      end
      ISSUE: cpu_st_d = WAIT;
      WAIT: begin
        cpu_st_d  = ACK;
        cpu_ack_d = 1'b1;
        if (!cpu_we_q) cpu_rdata_d = vram_rdata;
      end
      ACK:     cpu_st_d = IDLE;
      default: cpu_st_d = IDLE;
    endcase

    last_cpu_d = last_cpu_q;
    if (gnt == GNT_CPU) last_cpu_d = 1'b1;
    if (gnt == GNT_CLR) last_cpu_d = 1'b0;

    vram_en_d    = (gnt != GNT_NONE);
    vram_we_d    = 1'b0;
    vram_addr_d  = vram_addr_q;
    vram_wdata_d = vram_wdata_q;
    case (gnt)
      GNT_DISP: vram_addr_d = disp_addr(y[8:2], x[9:2]);
      GNT_CPU: begin
        vram_we_d    = cpu_we;
        vram_addr_d  = cpu_addr;
        vram_wdata_d = cpu_wdata;
      end
      GNT_CLR: begin
        vram_we_d    = 1'b1;
        vram_addr_d  = clr_addr;
        vram_wdata_d = clr_data;
      end
      default: ;
    endcase

    // pixel schedule: read data lands two cycles after the slot, shown one cycle later
    tick_d     = {tick_q[1:0], pix_tick};
    dvld_d     = {dvld_q[0], disp_slot};
    pix_hold_d = pix_hold_q;
    if (tick_q[1]) pix_hold_d = dvld_q[1] ? vram_rdata : 8'h00;
    pix_data_d = pix_data_q;
    if (tick_q[2]) pix_data_d = pix_hold_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_st_q     <= IDLE;
      cpu_we_q     <= 1'b0;
      cpu_ack_q    <= 1'b0;
      cpu_rdata_q  <= '0;
      last_cpu_q   <= 1'b0;
      vram_en_q    <= 1'b0;
      vram_we_q    <= 1'b0;
      vram_addr_q  <= '0;
      vram_wdata_q <= '0;
      tick_q       <= '0;
      dvld_q       <= '0;
      pix_hold_q   <= '0;
      pix_data_q   <= '0;
    end else begin
      cpu_st_q     <= cpu_st_d;
      cpu_we_q     <= cpu_we_d;
      cpu_ack_q    <= cpu_ack_d;
      cpu_rdata_q  <= cpu_rdata_d;
      last_cpu_q   <= last_cpu_d;
      vram_en_q    <= vram_en_d;
      vram_we_q    <= vram_we_d;
      vram_addr_q  <= vram_addr_d;
      vram_wdata_q <= vram_wdata_d;
      tick_q       <= tick_d;
      dvld_q       <= dvld_d;
      pix_hold_q   <= pix_hold_d;
      pix_data_q   <= pix_data_d;
    end
  end

  assign pix_data   = pix_data_q;
  assign cpu_ack    = cpu_ack_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign clear_busy = clr_busy;
  assign vram_en    = vram_en_q;
  assign vram_we    = vram_we_q;
  assign vram_addr  = vram_addr_q;
  assign vram_wdata = vram_wdata_q;
endmodule
